// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the pipeline MEM stage and a DMA/loader.
// The core has priority. A starvation counter forces in one DMA slot after STARVE_LIMIT contended cycles.
module dmem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_ack,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam logic [1:0] S_CORE = 2'd0;
  localparam logic [1:0] S_DMA  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_dma_ack;
  logic [WIDTH-1:0] r_dma_rdata;
  logic             w_grant;
  logic             w_contend;

  // An idle core grants DMA at once; a busy core yields only once the counter reaches its limit.
  always_comb begin
    w_grant   = 1'b0;
    w_contend = 1'b0;
    if (r_state == S_CORE) begin
      w_grant   = dma_req & (~core_req | (r_starve_cnt == STARVE_MAX));
      w_contend = dma_req & core_req & ~w_grant;
    end else begin
      w_grant   = 1'b0;
      w_contend = 1'b0;
    end
  end

  // next-state selection
  always_comb begin
    w_state_nxt = S_CORE;
    case (r_state)
      S_CORE:  w_state_nxt = w_grant ? S_DMA : S_CORE;
      S_DMA:   w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_CORE;
      default: w_state_nxt = S_CORE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CORE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The starvation count survives a dropped request and is cleared only by a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (w_grant) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (w_contend && (r_starve_cnt != CNT_SAT)) begin
      r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // capture DMA read data and raise the ack on the edge that ends the DMA slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= {WIDTH{1'b0}};
    end else if (r_state == S_DMA) begin
      r_dma_ack   <= 1'b1;
      r_dma_rdata <= mem_rd;
    end else begin
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= r_dma_rdata;
    end
  end

  // memory port mux
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {WIDTH{1'b0}};
    mem_wd   = {WIDTH{1'b0}};
    if (r_state == S_DMA) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_wd   = dma_wdata;
    end else begin
      mem_we   = core_we & core_req;
      mem_addr = core_addr;
      mem_wd   = core_wdata;
    end
  end

  assign core_stall = (r_state == S_DMA) & core_req;
  assign core_rdata = mem_rd;
  assign dma_ack    = r_dma_ack;
  assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed table/sequences plus a random run
// against a cycle-scheduled reference model.
module tb_dmem_port_arbiter;
  localparam int W   = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, core_stall;
  logic [W-1:0]  core_addr, core_wdata, core_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [W-1:0]  dma_addr, dma_wdata, dma_rdata;
  logic          mem_we;
  logic [W-1:0]  mem_addr, mem_wd, mem_rd;

  logic [W-1:0]  mem_arr [0:255];
  logic [W-1:0]  ref_mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem_arr[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wd;

  typedef struct {
    logic          core_req;
    logic [W-1:0]  core_addr;
    logic          dma_req;
    logic          exp_stall;
    logic          exp_ack;
    logic [W-1:0]  exp_mem_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  initial begin
    int ack_cnt;
    int t, slot_t, ack_t, contended, req_t;
    logic pending;
    logic [W-1:0] exp_rdata;
    logic in_slot, in_ack;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("reset_ack", {31'h0, dma_ack}, 32'h0);
    chk("reset_rdata", dma_rdata, 32'h0);
    chk("reset_stall", {31'h0, core_stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // 1: core-only traffic passes straight through
    for (int c = 0; c < 20; c++) begin
      core_req = 1'($urandom); core_we = 1'($urandom);
      core_addr = 32'($urandom_range(0, 15)) << 2; core_wdata = $urandom;
      @(negedge clk);
      chk("t1_stall", {31'h0, core_stall}, 32'h0);
      chk("t1_addr", mem_addr, core_addr);
      chk("t1_we", {31'h0, mem_we}, {31'h0, core_we & core_req});
      chk("t1_wd", mem_wd, core_wdata);
      @(posedge clk); #1;
    end
    idle_inputs();
    tick();

    // 2: DMA write with idle core, then core reads it back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_c0_we", {31'h0, mem_we}, 32'h0);
    chk("t2_c0_ack", {31'h0, dma_ack}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_slot_we", {31'h0, mem_we}, 32'h1);
    chk("t2_slot_addr", mem_addr, 32'h100);
    chk("t2_slot_wd", mem_wd, 32'hDEADBEEF);
    chk("t2_slot_ack", {31'h0, dma_ack}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_ack", {31'h0, dma_ack}, 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("t2_ack_drop", {31'h0, dma_ack}, 32'h0);
    @(posedge clk); #1;
    core_req = 1'b1; core_addr = 32'h100;
    @(negedge clk);
    chk("t2_readback", core_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    idle_inputs();

    // 3: starvation with continuous core traffic (table-driven)
    for (int i = 0; i < 7; i++) begin
      vecs[i].core_req     = 1'b1;
      vecs[i].core_addr    = 32'h8;
      vecs[i].dma_req      = (i < 6);
      vecs[i].exp_stall    = (i == 4);
      vecs[i].exp_ack      = (i == 5);
      vecs[i].exp_mem_addr = (i == 4) ? 32'h44 : 32'h8;
    end
    dma_we = 1'b0; dma_addr = 32'h44;
    for (int i = 0; i < 7; i++) begin
      core_req = vecs[i].core_req; core_addr = vecs[i].core_addr; dma_req = vecs[i].dma_req;
      @(negedge clk);
      chk($sformatf("t3_stall_c%0d", i), {31'h0, core_stall}, {31'h0, vecs[i].exp_stall});
      chk($sformatf("t3_ack_c%0d", i), {31'h0, dma_ack}, {31'h0, vecs[i].exp_ack});
      chk($sformatf("t3_addr_c%0d", i), mem_addr, vecs[i].exp_mem_addr);
      @(posedge clk); #1;
    end
    idle_inputs();

    // 4: core and DMA write the same word; core wins first, DMA lands in the forced slot
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h22222222;
    core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h11111111;
    for (int c = 0; c < 6; c++) begin
      core_req = (c < 4);
      @(negedge clk);
      if (c == 0) chk("t4_core_wins", mem_wd, 32'h11111111);
      if (c == 4) chk("t4_dma_slot", mem_wd, 32'h22222222);
      if (c == 5) chk("t4_ack", {31'h0, dma_ack}, 32'h1);
      @(posedge clk); #1;
      if (c == 1) chk("t4_core_data", mem_arr[8'h20], 32'h11111111);
    end
    idle_inputs();
    tick();
    chk("t4_final", mem_arr[8'h20], 32'h22222222);

    // 5: DMA read held through the ack cycle gets exactly one ack
    mem_arr[8'h10] = 32'hCAFEF00D;
    ack_cnt = 0;
    dma_addr = 32'h40;
    for (int c = 0; c < 7; c++) begin
      dma_req = (c < 3);
      @(negedge clk);
      if (dma_ack) begin
        ack_cnt++;
        chk("t5_rdata", dma_rdata, 32'hCAFEF00D);
      end
      @(posedge clk); #1;
    end
    chk("t5_ack_count", 32'(ack_cnt), 32'd1);
    idle_inputs();

    // 6: reset during the DMA write slot
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h55555555;
    tick();
    rst = 1'b0;
    core_req = 1'b1;
    @(negedge clk);
    chk("t6_ack", {31'h0, dma_ack}, 32'h0);
    chk("t6_stall", {31'h0, core_stall}, 32'h0);
    chk("t6_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("t6_mem", mem_arr[8'h80], 32'h0);
    idle_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_ack_after", {31'h0, dma_ack}, 32'h0);
    @(posedge clk); #1;

    // random traffic against a cycle-scheduled model
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    t = 0; slot_t = -1; ack_t = -1; contended = 0; req_t = 0; pending = 1'b0;
    exp_rdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      core_req = ($urandom_range(0, 3) != 0); core_we = 1'($urandom);
      core_addr = 32'($urandom_range(0, 15)) << 2; core_wdata = $urandom;
      if (pending && dma_ack) begin
        pending = 1'b0; dma_req = 1'b0;
      end else if (!pending && !dma_ack && ($urandom_range(0, 2) == 0)) begin
        pending = 1'b1; dma_req = 1'b1; req_t = t; dma_we = 1'($urandom);
        dma_addr = 32'($urandom_range(0, 15)) << 2; dma_wdata = $urandom;
      end
      @(negedge clk);
      in_slot = (t == slot_t);
      in_ack  = (t == ack_t);
      chk("r_stall", {31'h0, core_stall}, {31'h0, in_slot & core_req});
      chk("r_ack", {31'h0, dma_ack}, {31'h0, in_ack});
      chk("r_addr", mem_addr, in_slot ? dma_addr : core_addr);
      chk("r_we", {31'h0, mem_we}, {31'h0, in_slot ? dma_we : (core_we & core_req)});
      if (in_ack) begin
        chk("r_dma_rdata", dma_rdata, exp_rdata);
        chk("r_latency", 32'(t - req_t <= LIM + 1), 32'd1);
      end
      if (!in_slot && core_req && !core_we)
        chk("r_core_rdata", core_rdata, ref_mem[core_addr[9:2]]);
      if (in_slot) begin
        exp_rdata = ref_mem[dma_addr[9:2]];
        if (dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
      end else if (core_req && core_we) begin
        ref_mem[core_addr[9:2]] = core_wdata;
      end
      if (!in_slot && !in_ack && dma_req) begin
        if (!core_req || contended == LIM - 1) begin
          slot_t = t + 1; ack_t = t + 2; contended = 0;
        end else begin
          contended++;
        end
      end
      t++;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
